// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment display path.
// Segment order is {a,b,c,d,e,f,g} with bit 6 = a.
package seg7_pkg;

   typedef logic [6:0] seg7_t;
   typedef logic [3:0] bcd_t;

   localparam seg7_t SEG7_0 = 7'h7E;
   localparam seg7_t SEG7_1 = 7'h30;
   localparam seg7_t SEG7_2 = 7'h6D;
   localparam seg7_t SEG7_3 = 7'h79;
   localparam seg7_t SEG7_4 = 7'h33;
   localparam seg7_t SEG7_5 = 7'h5B;
   localparam seg7_t SEG7_6 = 7'h5F;
   localparam seg7_t SEG7_7 = 7'h70;
   localparam seg7_t SEG7_8 = 7'h7F;
   localparam seg7_t SEG7_9 = 7'h73;

   localparam bcd_t BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      StIdle,
      StCount,
      StLocked
   } scan_state_e;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder; inverse of the BCD-to-7-segment encoder.
// Unrecognised patterns decode to BCD_INVALID with err set.
module seg7_pattern_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       err_o
);

   always_comb begin
      bcd_o = BCD_INVALID;
      err_o = 1'b0;
      case (seg_i)
         SEG7_0:  bcd_o = 4'd0;
         SEG7_1:  bcd_o = 4'd1;
         SEG7_2:  bcd_o = 4'd2;
         SEG7_3:  bcd_o = 4'd3;
         SEG7_4:  bcd_o = 4'd4;
         SEG7_5:  bcd_o = 4'd5;
         SEG7_6:  bcd_o = 4'd6;
         SEG7_7:  bcd_o = 4'd7;
         SEG7_8:  bcd_o = 4'd8;
         SEG7_9:  bcd_o = 4'd9;
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Captures a scanned 7-segment display back into per-digit BCD frames (valid/ready out).
// Define SEG7_ACTIVE_LOW_EN to invert seg_i/dig_en_i at the input register (common anode).
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_i,
   input  logic [NUM_DIGITS-1:0]   dig_en_i,
   output logic                    frame_valid_o,
   input  logic                    frame_ready_i,
   output logic [4*NUM_DIGITS-1:0] frame_bcd_o,
   output logic [NUM_DIGITS-1:0]   frame_err_o,
   output logic                    cap_pulse_o
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [6:0]              seg_in, seg_q, seg_prev_q;
   logic [NUM_DIGITS-1:0]   dig_in, dig_q, dig_prev_q;
   scan_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    one_hot, changed, capture;
   logic [IDX_W-1:0]        dig_idx;
   logic [3:0]              dec_bcd;
   logic                    dec_err;
   logic [4*NUM_DIGITS-1:0] digit_bcd_q;
   logic [NUM_DIGITS-1:0]   digit_err_q, seen_q, seen_d;
   logic                    load;
   logic                    frame_valid_q, cap_pulse_q;
   logic [4*NUM_DIGITS-1:0] frame_bcd_q;
   logic [NUM_DIGITS-1:0]   frame_err_q;

`ifdef SEG7_ACTIVE_LOW_EN
   assign seg_in = ~seg_i;
   assign dig_in = ~dig_en_i;
`else
   assign seg_in = seg_i;
   assign dig_in = dig_en_i;
`endif

   // Previous sample lets us detect any change of strobe or segments within a dwell.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q      <= '0;
         dig_q      <= '0;
         seg_prev_q <= '0;
         dig_prev_q <= '0;
      end else begin
         seg_q      <= seg_in;
         dig_q      <= dig_in;
         seg_prev_q <= seg_q;
         dig_prev_q <= dig_q;
      end
   end

   assign one_hot = (dig_q != '0) && ((dig_q & (dig_q - 1'b1)) == '0);
   assign changed = (seg_q != seg_prev_q) || (dig_q != dig_prev_q);

   always_comb begin
      dig_idx = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (dig_q[k]) dig_idx = IDX_W'(k);
      end
   end

   seg7_pattern_to_bcd u_dec (
      .seg_i (seg_q),
      .bcd_o (dec_bcd),
      .err_o (dec_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!one_hot) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (state_q == StIdle || changed) begin
         state_d = StCount;
         cnt_d   = CNT_W'(1);
      end else if (state_q == StCount) begin
         if (cnt_q >= CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = StLocked;
            cnt_d   = CNT_W'(STABLE_CYCLES);
            capture = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // A new frame may load on the same edge the pending one is taken (back-to-back).
   assign load = (&seen_q) && (!frame_valid_q || frame_ready_i);

   always_comb begin
      seen_d = seen_q;
      if (load) seen_d = '0;
      if (capture) seen_d[dig_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         seen_q        <= '0;
         digit_bcd_q   <= '0;
         digit_err_q   <= '0;
         cap_pulse_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_bcd_q   <= '0;
         frame_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seen_q      <= seen_d;
         cap_pulse_q <= capture;
         if (capture) begin
            digit_bcd_q[4*dig_idx +: 4] <= dec_bcd;
            digit_err_q[dig_idx]        <= dec_err;
         end
         if (load) begin
            frame_valid_q <= 1'b1;
            frame_bcd_q   <= digit_bcd_q;
            frame_err_q   <= digit_err_q;
         end else if (frame_ready_i) begin
            frame_valid_q <= 1'b0;
         end
      end
   end

   assign frame_valid_o = frame_valid_q;
   assign frame_bcd_o   = frame_bcd_q;
   assign frame_err_o   = frame_err_q;
   assign cap_pulse_o   = cap_pulse_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: captures, glitch filtering, errors, backpressure, reset.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  dig;
   logic        ready;
   logic        frame_valid;
   logic [15:0] frame_bcd;
   logic [3:0]  frame_err;
   logic        cap_pulse;

   int checks = 0;
   int errors = 0;
   int caps   = 0;
   int vcyc   = 0;
   logic [15:0] acc_bcd[$];
   logic [3:0]  acc_err[$];

   seg7_scan_decoder #(
      .NUM_DIGITS    (4),
      .STABLE_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .seg_i         (seg),
      .dig_en_i      (dig),
      .frame_valid_o (frame_valid),
      .frame_ready_i (ready),
      .frame_bcd_o   (frame_bcd),
      .frame_err_o   (frame_err),
      .cap_pulse_o   (cap_pulse)
   );

   always #5 clk = ~clk;

   // Monitor on the falling edge: capture pulses, valid cycles and accepted frames.
   always @(negedge clk) begin
      if (cap_pulse === 1'b1) caps++;
      if (frame_valid === 1'b1) vcyc++;
      if (frame_valid === 1'b1 && ready === 1'b1) begin
         acc_bcd.push_back(frame_bcd);
         acc_err.push_back(frame_err);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int n);
      dig = d;
      seg = s;
      cyc(n);
   endtask

   task automatic clear_mon();
      caps = 0;
      vcyc = 0;
      acc_bcd.delete();
      acc_err.delete();
   endtask

   // Check that exactly one frame was accepted and that it matches.
   task automatic check_one_frame(input string tag, input logic [15:0] b, input logic [3:0] e);
      check_eq({tag, "_nframes"}, acc_bcd.size(), 1);
      if (acc_bcd.size() > 0) begin
         check_eq({tag, "_bcd"}, acc_bcd[0], b);
         check_eq({tag, "_err"}, acc_err[0], e);
      end
   endtask

   initial begin
      rst   = 1'b1;
      dig   = '0;
      seg   = '0;
      ready = 1'b1;
      cyc(3);
      check_eq("rst_valid", frame_valid, 0);
      check_eq("rst_bcd", frame_bcd, 0);
      check_eq("rst_err", frame_err, 0);
      check_eq("rst_cap", cap_pulse, 0);
      rst = 1'b0;
      clear_mon();

      // Single digit held exactly STABLE_CYCLES samples.
      dwell(4'b0001, 7'h30, 4);
      dwell(4'b0000, 7'h00, 4);
      check_eq("t1_caps", caps, 1);
      check_eq("t1_valid", frame_valid, 0);
      dwell(4'b0010, 7'h6D, 6);
      dwell(4'b0100, 7'h5F, 6);
      dwell(4'b1000, 7'h73, 6);
      dwell(4'b0000, 7'h00, 4);
      check_eq("t1_caps_total", caps, 4);
      check_one_frame("t1", 16'h9621, 4'b0000);
      check_eq("t1_vcyc", vcyc, 1);

      // Full scan with consumer always ready.
      clear_mon();
      dwell(4'b0001, 7'h7E, 6);
      dwell(4'b0010, 7'h6D, 6);
      dwell(4'b0100, 7'h5F, 6);
      dwell(4'b1000, 7'h73, 6);
      dwell(4'b0000, 7'h00, 4);
      check_eq("t2_caps", caps, 4);
      check_one_frame("t2", 16'h9620, 4'b0000);
      check_eq("t2_vcyc", vcyc, 1);

      // Glitching segments on digit 2 never stabilise; then settle on 8.
      clear_mon();
      for (int i = 0; i < 5; i++) dwell(4'b0100, (i % 2 == 0) ? 7'h79 : 7'h7F, 2);
      check_eq("t3_glitch_caps", caps, 0);
      dwell(4'b0100, 7'h7F, 4);
      dwell(4'b0000, 7'h00, 3);
      check_eq("t3_settle_caps", caps, 1);
      dwell(4'b0010, 7'h41, 6);
      dwell(4'b0001, 7'h7E, 6);
      dwell(4'b1000, 7'h73, 6);
      dwell(4'b0000, 7'h00, 4);
      check_one_frame("t3", 16'h98F0, 4'b0010);

      // Backpressure: pending frame held while digit 0 is rescanned to 3.
      clear_mon();
      ready = 1'b0;
      dwell(4'b0001, 7'h7E, 6);
      dwell(4'b0010, 7'h6D, 6);
      dwell(4'b0100, 7'h5F, 6);
      dwell(4'b1000, 7'h73, 6);
      dwell(4'b0000, 7'h00, 4);
      check_eq("t4_pend_valid", frame_valid, 1);
      check_eq("t4_pend_bcd", frame_bcd, 16'h9620);
      dwell(4'b0001, 7'h79, 6);
      dwell(4'b0010, 7'h6D, 6);
      dwell(4'b0100, 7'h5F, 6);
      dwell(4'b1000, 7'h73, 6);
      dwell(4'b0000, 7'h00, 4);
      check_eq("t4_hold_valid", frame_valid, 1);
      check_eq("t4_hold_bcd", frame_bcd, 16'h9620);
      check_eq("t4_hold_err", frame_err, 0);
      check_eq("t4_none_taken", acc_bcd.size(), 0);
      ready = 1'b1;
      cyc(4);
      check_eq("t4_nframes", acc_bcd.size(), 2);
      if (acc_bcd.size() > 1) begin
         check_eq("t4_first_bcd", acc_bcd[0], 16'h9620);
         check_eq("t4_second_bcd", acc_bcd[1], 16'h9623);
         check_eq("t4_second_err", acc_err[1], 0);
      end
      check_eq("t4_valid_drop", frame_valid, 0);

      // Non-one-hot strobe never captures.
      clear_mon();
      dwell(4'b0011, 7'h30, 8);
      dwell(4'b0000, 7'h00, 3);
      check_eq("t5_nonhot_caps", caps, 0);
      check_eq("t5_nonhot_valid", frame_valid, 0);

      // Reset mid-dwell discards a pending frame and restarts the counter.
      ready = 1'b0;
      dwell(4'b0001, 7'h7E, 6);
      dwell(4'b0010, 7'h30, 6);
      dwell(4'b0100, 7'h6D, 6);
      dwell(4'b1000, 7'h79, 6);
      dwell(4'b0000, 7'h00, 4);
      check_eq("t5_pend_bcd", frame_bcd, 16'h3210);
      caps = 0;
      dwell(4'b0001, 7'h30, 2);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(2);
      dwell(4'b0000, 7'h00, 3);
      check_eq("t5_rst_caps", caps, 0);
      check_eq("t5_rst_valid", frame_valid, 0);
      check_eq("t5_rst_bcd", frame_bcd, 0);
      ready = 1'b1;
      dwell(4'b0001, 7'h30, 4);
      dwell(4'b0000, 7'h00, 3);
      check_eq("t5_after_caps", caps, 1);
      check_eq("t5_after_valid", frame_valid, 0);
      check_eq("t5_after_frames", acc_bcd.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
